// File: rtl/dcache_ctrl.sv
// Sequencing FSM for a direct-mapped data-cache tag array: init sweep, hit check, dirty writeback, line refill.
// Optional hit/miss/writeback counters are compiled in with `define DCACHE_CTRL_PERF_EN.
module dcache_ctrl #(
  parameter int IDX_W      = 7,
  parameter int TAG_W      = 20,
  parameter int OFF_W      = 5,
  parameter int LINE_WORDS = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          cpu_req,
  input  logic                          cpu_wr,
  input  logic [31:0]                   cpu_addr,
  output logic                          cpu_addr_ok,
  output logic                          cpu_data_ok,
  output logic                          tag_wen,
  output logic                          valid_wen,
  output logic                          dirty_wen,
  output logic [IDX_W-1:0]              qidx,
  output logic [IDX_W-1:0]              widx,
  output logic [TAG_W-1:0]              tag_query,
  output logic [TAG_W-1:0]              tag_write,
  output logic                          valid_in,
  output logic                          dirty_in,
  input  logic                          hit,
  input  logic [TAG_W-1:0]              tag_out,
  input  logic                          valid_out,
  input  logic                          dirty_out,
  output logic                          wr_req,
  output logic [31:0]                   wr_addr,
  input  logic                          wr_rdy,
  input  logic                          wr_done,
  output logic                          rd_req,
  output logic [31:0]                   rd_addr,
  input  logic                          rd_rdy,
  input  logic                          ret_valid,
  input  logic                          ret_last,
  output logic                          refill_we,
  output logic [$clog2(LINE_WORDS)-1:0] refill_word,
  output logic                          busy
`ifdef DCACHE_CTRL_PERF_EN
  ,
  output logic [31:0]                   perf_hit,
  output logic [31:0]                   perf_miss,
  output logic [31:0]                   perf_wb
`endif
);

  localparam int WORD_W = $clog2(LINE_WORDS);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_LOOKUP,
    S_WB_REQ,
    S_WB_WAIT,
    S_RF_REQ,
    S_REFILL,
    S_UPDATE
  } state_t;

  state_t             state;
  logic [IDX_W:0]     init_cnt;
  logic               req_wr;
  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic [TAG_W-1:0]   victim_tag;
  logic               unused_offset;

  assign unused_offset = ^cpu_addr[OFF_W-1:0];

  // Handshake and query mux are decoded from the state register; write strobes are registered.
  assign cpu_addr_ok = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign wr_req      = (state == S_WB_REQ);
  assign rd_req      = (state == S_RF_REQ);
  assign refill_we   = (state == S_REFILL) && ret_valid;
  assign qidx        = (state == S_IDLE) ? cpu_addr[OFF_W +: IDX_W] : req_idx;
  assign tag_query   = (state == S_IDLE) ? cpu_addr[OFF_W+IDX_W +: TAG_W] : req_tag;
  assign wr_addr     = {victim_tag, req_idx, {OFF_W{1'b0}}};
  assign rd_addr     = {req_tag, req_idx, {OFF_W{1'b0}}};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_INIT;
      init_cnt    <= '0;
      req_wr      <= 1'b0;
      req_idx     <= '0;
      req_tag     <= '0;
      victim_tag  <= '0;
      refill_word <= '0;
      cpu_data_ok <= 1'b0;
      tag_wen     <= 1'b0;
      valid_wen   <= 1'b0;
      dirty_wen   <= 1'b0;
      widx        <= '0;
      tag_write   <= '0;
      valid_in    <= 1'b0;
      dirty_in    <= 1'b0;
    end else begin
      cpu_data_ok <= 1'b0;
      tag_wen     <= 1'b0;
      valid_wen   <= 1'b0;
      dirty_wen   <= 1'b0;
      case (state)
        // Extra counter bit gives one spare cycle so the last clear does not overlap IDLE.
        S_INIT: begin
          if (!init_cnt[IDX_W]) begin
            valid_wen <= 1'b1;
            dirty_wen <= 1'b1;
            valid_in  <= 1'b0;
            dirty_in  <= 1'b0;
            widx      <= init_cnt[IDX_W-1:0];
            init_cnt  <= init_cnt + (IDX_W+1)'(1);
          end else begin
            state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (cpu_req) begin
            req_wr  <= cpu_wr;
            req_idx <= cpu_addr[OFF_W +: IDX_W];
            req_tag <= cpu_addr[OFF_W+IDX_W +: TAG_W];
            state   <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            cpu_data_ok <= 1'b1;
            if (req_wr) begin
              dirty_wen <= 1'b1;
              dirty_in  <= 1'b1;
              widx      <= req_idx;
            end
            state <= S_IDLE;
          end else if (valid_out && dirty_out) begin
            victim_tag <= tag_out;
            state      <= S_WB_REQ;
          end else begin
            state <= S_RF_REQ;
          end
        end
        S_WB_REQ: begin
          if (wr_rdy) begin
            state <= wr_done ? S_RF_REQ : S_WB_WAIT;
          end
        end
        S_WB_WAIT: begin
          if (wr_done) begin
            state <= S_RF_REQ;
          end
        end
        S_RF_REQ: begin
          if (rd_rdy) begin
            refill_word <= '0;
            state       <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (ret_valid) begin
            refill_word <= refill_word + WORD_W'(1);
            if (ret_last) begin
              tag_wen     <= 1'b1;
              valid_wen   <= 1'b1;
              dirty_wen   <= 1'b1;
              widx        <= req_idx;
              tag_write   <= req_tag;
              valid_in    <= 1'b1;
              dirty_in    <= req_wr;
              cpu_data_ok <= 1'b1;
              state       <= S_UPDATE;
            end
          end
        end
        S_UPDATE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

`ifdef DCACHE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_hit  <= '0;
      perf_miss <= '0;
      perf_wb   <= '0;
    end else if (state == S_LOOKUP) begin
      if (hit) begin
        perf_hit <= perf_hit + 32'd1;
      end else begin
        perf_miss <= perf_miss + 32'd1;
        if (valid_out && dirty_out) begin
          perf_wb <= perf_wb + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: behavioural tag array with write forwarding, bridge driven by hand.
module tb_dcache_ctrl;
  localparam int IDX_W      = 7;
  localparam int TAG_W      = 20;
  localparam int OFF_W      = 5;
  localparam int LINE_WORDS = 8;

  logic             clk = 1'b0;
  logic             resetn;
  logic             cpu_req, cpu_wr;
  logic [31:0]      cpu_addr;
  logic             cpu_addr_ok, cpu_data_ok;
  logic             tag_wen, valid_wen, dirty_wen;
  logic [IDX_W-1:0] qidx, widx;
  logic [TAG_W-1:0] tag_query, tag_write;
  logic             valid_in, dirty_in;
  logic             hit;
  logic [TAG_W-1:0] tag_out;
  logic             valid_out, dirty_out;
  logic             wr_req, wr_rdy, wr_done;
  logic [31:0]      wr_addr, rd_addr;
  logic             rd_req, rd_rdy;
  logic             ret_valid, ret_last;
  logic             refill_we;
  logic [2:0]       refill_word;
  logic             busy;
`ifdef DCACHE_CTRL_PERF_EN
  logic [31:0]      perf_hit, perf_miss, perf_wb;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  dcache_ctrl #(
    .IDX_W(IDX_W), .TAG_W(TAG_W), .OFF_W(OFF_W), .LINE_WORDS(LINE_WORDS)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok),
    .tag_wen(tag_wen), .valid_wen(valid_wen), .dirty_wen(dirty_wen),
    .qidx(qidx), .widx(widx), .tag_query(tag_query), .tag_write(tag_write),
    .valid_in(valid_in), .dirty_in(dirty_in),
    .hit(hit), .tag_out(tag_out), .valid_out(valid_out), .dirty_out(dirty_out),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_rdy(wr_rdy), .wr_done(wr_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last),
    .refill_we(refill_we), .refill_word(refill_word), .busy(busy)
`ifdef DCACHE_CTRL_PERF_EN
    , .perf_hit(perf_hit), .perf_miss(perf_miss), .perf_wb(perf_wb)
`endif
  );

  // Tag array: combinational read with same-cycle write forwarding, registered hit.
  logic [TAG_W-1:0] m_tag   [0:(1<<IDX_W)-1];
  logic             m_valid [0:(1<<IDX_W)-1];
  logic             m_dirty [0:(1<<IDX_W)-1];

  always_comb begin
    tag_out   = m_tag[qidx];
    valid_out = m_valid[qidx];
    dirty_out = m_dirty[qidx];
    if (tag_wen && widx == qidx)   tag_out   = tag_write;
    if (valid_wen && widx == qidx) valid_out = valid_in;
    if (dirty_wen && widx == qidx) dirty_out = dirty_in;
  end

  always @(posedge clk) begin
    hit <= valid_out && (tag_out == tag_query);
    if (tag_wen)   m_tag[widx]   <= tag_write;
    if (valid_wen) m_valid[widx] <= valid_in;
    if (dirty_wen) m_dirty[widx] <= dirty_in;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic run_init();
    for (int i = 0; i < (1 << IDX_W); i++) begin
      @(negedge clk);
      check("init_sweep", 32'({valid_wen, dirty_wen, valid_in, dirty_in, cpu_addr_ok, widx}),
            32'({5'b11000, IDX_W'(i)}));
    end
    @(negedge clk);
    check("init_done", 32'({cpu_addr_ok, busy, valid_wen, dirty_wen}), 32'b1000);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the LOOKUP cycle.
  task automatic issue(input logic wr, input logic [31:0] addr);
    logic [31:0] a;
    a = addr;
    cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr;
    #1;
    check("addr_ok", 32'(cpu_addr_ok), 32'd1);
    check("qidx", 32'(qidx), 32'(a[11:5]));
    check("tag_query", 32'(tag_query), 32'(a[31:12]));
    @(negedge clk);
    cpu_req = 1'b0; cpu_wr = 1'b0;
    check("lookup_quiet", 32'({cpu_data_ok, busy, rd_req, wr_req}), 32'b0100);
  endtask

  task automatic refill(input int first, input int beats, input bit last);
    for (int k = 0; k < beats; k++) begin
      ret_valid = 1'b1; ret_last = last && (k == beats - 1);
      #1;
      check("refill_we", 32'(refill_we), 32'd1);
      check("refill_word", 32'(refill_word), 32'((first + k) % LINE_WORDS));
      @(negedge clk);
    end
    ret_valid = 1'b0; ret_last = 1'b0;
  endtask

  // At the UPDATE negedge; returns at the following IDLE negedge.
  task automatic expect_update(input logic [TAG_W-1:0] t, input logic d);
    check("upd_strobes", 32'({tag_wen, valid_wen, dirty_wen, valid_in, dirty_in, cpu_data_ok}),
          32'({4'b1111, d, 1'b1}));
    check("upd_widx", 32'(widx), 32'd2);
    check("upd_tag", 32'(tag_write), 32'(t));
    @(negedge clk);
    check("post_upd", 32'({cpu_data_ok, cpu_addr_ok, tag_wen}), 32'b010);
  endtask

  initial begin
    resetn = 1'b0; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0;
    wr_rdy = 1'b0; wr_done = 1'b0; rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_outs", 32'({cpu_addr_ok, cpu_data_ok, valid_wen, dirty_wen, tag_wen, wr_req, rd_req, refill_we}), 32'd0);
    resetn = 1'b1;
    run_init();

    // Cold miss with a refill stall in the middle
    issue(1'b0, 32'h0000_1040);
    @(negedge clk);
    check("miss_rd_req", 32'({rd_req, wr_req}), 32'b10);
    check("miss_rd_addr", rd_addr, 32'h0000_1040);
    @(negedge clk);
    check("rd_req_held", 32'(rd_req), 32'd1);
    rd_rdy = 1'b1;
    @(negedge clk);
    rd_rdy = 1'b0;
    check("rd_req_drop", 32'(rd_req), 32'd0);
    refill(0, 4, 1'b0);
    #1;
    check("gap_we", 32'(refill_we), 32'd0);
    check("gap_word", 32'(refill_word), 32'd4);
    @(negedge clk);
    refill(4, 4, 1'b1);
    expect_update(20'h00001, 1'b0);

    // Load hit, then back-to-back store hit
    issue(1'b0, 32'h0000_1044);
    @(negedge clk);
    check("hit_ld", 32'({cpu_data_ok, rd_req, dirty_wen}), 32'b100);
    issue(1'b1, 32'h0000_1048);
    @(negedge clk);
    check("hit_st", 32'({cpu_data_ok, dirty_wen, dirty_in, tag_wen, valid_wen}), 32'b11100);
    check("hit_st_widx", 32'(widx), 32'd2);

    // Dirty victim: writeback with a separate wr_done, then refill
    issue(1'b0, 32'h0000_3040);
    @(negedge clk);
    check("wb_req", 32'({wr_req, rd_req}), 32'b10);
    check("wb_addr", wr_addr, 32'h0000_1040);
    @(negedge clk);
    check("wb_held", 32'(wr_req), 32'd1);
    wr_rdy = 1'b1;
    @(negedge clk);
    wr_rdy = 1'b0;
    check("wb_wait", 32'({wr_req, rd_req, busy}), 32'b001);
    @(negedge clk);
    check("wb_wait2", 32'(rd_req), 32'd0);
    wr_done = 1'b1;
    @(negedge clk);
    wr_done = 1'b0;
    check("rf_after_wb", 32'(rd_req), 32'd1);
    check("rf_addr2", rd_addr, 32'h0000_3040);
    rd_rdy = 1'b1;
    @(negedge clk);
    rd_rdy = 1'b0;
    refill(0, 8, 1'b1);
    expect_update(20'h00003, 1'b0);

    // wr_rdy and wr_done together; single-beat refill
    issue(1'b1, 32'h0000_3050);
    @(negedge clk);
    check("hit_st2", 32'({cpu_data_ok, dirty_wen, dirty_in}), 32'b111);
    issue(1'b0, 32'h0000_5040);
    @(negedge clk);
    check("wb2_addr", wr_addr, 32'h0000_3040);
    check("wb2_req", 32'(wr_req), 32'd1);
    wr_rdy = 1'b1; wr_done = 1'b1;
    @(negedge clk);
    wr_rdy = 1'b0; wr_done = 1'b0;
    check("skip_wait", 32'({wr_req, rd_req}), 32'b01);
    check("rf_addr3", rd_addr, 32'h0000_5040);
    rd_rdy = 1'b1;
    @(negedge clk);
    rd_rdy = 1'b0;
    refill(0, 1, 1'b1);
    expect_update(20'h00005, 1'b0);

    // Clean victim, then reset mid-refill
    issue(1'b0, 32'h0000_7040);
    @(negedge clk);
    check("clean_miss", 32'({rd_req, wr_req}), 32'b10);
    rd_rdy = 1'b1;
    @(negedge clk);
    rd_rdy = 1'b0;
    refill(0, 2, 1'b0);
    ret_valid = 1'b1;
    #1;
    check("pre_rst_we", 32'(refill_we), 32'd1);
    resetn = 1'b0;
    #1;
    check("async_rst", 32'({refill_we, rd_req, wr_req, cpu_addr_ok, cpu_data_ok, valid_wen, dirty_wen, tag_wen}), 32'd0);
    check("async_rst_word", 32'(refill_word), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd1);
    ret_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    run_init();
    issue(1'b0, 32'h0000_1040);
    @(negedge clk);
    check("reinit_miss", 32'(rd_req), 32'd1);
    check("reinit_addr", rd_addr, 32'h0000_1040);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
